// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC time-set field blocks
// (field_adjust, alarm and timer).
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } state_t;

  localparam logic A_D_ADDR  = 1'b0;
  localparam logic A_D_DATA  = 1'b1;
  localparam logic W_R_WRITE = 1'b1;

  localparam logic [7:0] ADDR_SEC  = 8'h21;
  localparam logic [7:0] ADDR_MIN  = 8'h22;
  localparam logic [7:0] ADDR_HOUR = 8'h23;
  localparam logic [7:0] ADDR_DAY  = 8'h24;
  localparam logic [7:0] ADDR_MON  = 8'h25;
  localparam logic [7:0] ADDR_YEAR = 8'h26;

  function automatic logic bcd_valid(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Range bounds come in as arguments so a zero lower bound is not folded
  // into an always-true compare.
  function automatic logic bcd_in_range(input logic [7:0] v, input logic [7:0] lo,
                                        input logic [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/bcd_step.sv
// Combinational +/-1 step of a two-digit BCD value with range wrap or
// saturate; any malformed or out-of-range input collapses to MIN_BCD.
module bcd_step
  import rtc_pkg::*;
#(
  parameter logic [7:0] MIN_BCD = 8'h00,
  parameter logic [7:0] MAX_BCD = 8'h23,
  parameter bit         WRAP    = 1'b1
) (
  input  logic [7:0] cur,
  input  logic       up,
  input  logic       down,
  output logic [7:0] next
);

  logic [3:0] hi;
  logic [3:0] lo;

  assign hi = cur[7:4];
  assign lo = cur[3:0];

  always_comb begin
    next = cur;
    if (!bcd_valid(cur) || !bcd_in_range(cur, MIN_BCD, MAX_BCD)) begin
      next = MIN_BCD;
    end else if (up && !down) begin
      if (cur == MAX_BCD)  next = WRAP ? MIN_BCD : MAX_BCD;
      else if (lo == 4'd9) next = {hi + 4'd1, 4'd0};
      else                 next = {hi, lo + 4'd1};
    end else if (down && !up) begin
      if (cur == MIN_BCD)  next = WRAP ? MAX_BCD : MIN_BCD;
      else if (lo == 4'd0) next = {hi - 4'd1, 4'd9};
      else                 next = {hi, lo - 4'd1};
    end
  end

endmodule

// File: rtl/rtc_field_adjust.sv
// One RTC time/date field: steps the BCD value on request and writes it back
// over the two-phase RTC bus, with optional auto-repeat while a key is held.
module rtc_field_adjust
  import rtc_pkg::*;
#(
  parameter logic [7:0] FIELD_ADDR    = ADDR_HOUR,
  parameter logic [7:0] MIN_BCD       = 8'h00,
  parameter logic [7:0] MAX_BCD       = 8'h23,
  parameter bit         WRAP          = 1'b1,
  parameter int         PHASE_CYCLES  = 2,
  parameter int         REPEAT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       start,
  input  logic       UP,
  input  logic       DOWN,
  input  logic [7:0] cur_bcd,
  output logic       A_D,
  output logic       W_R,
  output logic [7:0] bus_out,
  output logic       flag_addr,
  output logic       flag_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] new_bcd
);

  localparam bit         RPT_EN   = (REPEAT_CYCLES > 0);
  localparam logic [15:0] PH_LAST  = 16'(PHASE_CYCLES - 1);
  localparam logic [15:0] RPT_LAST = 16'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  state_t      state;
  logic [15:0] ph_cnt;
  logic [15:0] rpt_cnt;
  logic        up_p0;
  logic        down_p0;
  logic [7:0]  step_next;
  logic        one_dir;
  logic        repeat_fire;
  logic        trigger;

  assign one_dir     = UP ^ DOWN;
  assign repeat_fire = RPT_EN && one_dir && (rpt_cnt == RPT_LAST);
  assign trigger     = start | repeat_fire;

  bcd_step #(
    .MIN_BCD (MIN_BCD),
    .MAX_BCD (MAX_BCD),
    .WRAP    (WRAP)
  ) u_step (
    .cur  (cur_bcd),
    .up   (up_p0),
    .down (down_p0),
    .next (step_next)
  );

  // The repeat count keeps running while busy, so a fire that lands during a
  // write is simply lost and the next one is a full period later.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      rpt_cnt <= '0;
    end else if (!RPT_EN || !one_dir || repeat_fire) begin
      rpt_cnt <= '0;
    end else begin
      rpt_cnt <= rpt_cnt + 16'd1;
    end
  end

  // Direction is frozen at trigger; the step result is captured on leaving CALC.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state     <= ST_IDLE;
      ph_cnt    <= '0;
      up_p0     <= 1'b0;
      down_p0   <= 1'b0;
      new_bcd   <= '0;
      A_D       <= A_D_ADDR;
      W_R       <= 1'b0;
      bus_out   <= '0;
      flag_addr <= 1'b0;
      flag_data <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            state   <= ST_CALC;
            busy    <= 1'b1;
            up_p0   <= UP;
            down_p0 <= DOWN;
          end
        end
        ST_CALC: begin
          new_bcd   <= step_next;
          state     <= ST_ADDR;
          ph_cnt    <= '0;
          A_D       <= A_D_ADDR;
          W_R       <= 1'b0;
          bus_out   <= FIELD_ADDR;
          flag_addr <= 1'b1;
        end
        ST_ADDR: begin
          if (ph_cnt == PH_LAST) begin
            state     <= ST_DATA;
            ph_cnt    <= '0;
            A_D       <= A_D_DATA;
            W_R       <= W_R_WRITE;
            bus_out   <= new_bcd;
            flag_addr <= 1'b0;
            flag_data <= 1'b1;
          end else begin
            ph_cnt <= ph_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (ph_cnt == PH_LAST) begin
            state     <= ST_DONE;
            ph_cnt    <= '0;
            A_D       <= A_D_ADDR;
            W_R       <= 1'b0;
            bus_out   <= '0;
            flag_data <= 1'b0;
            done      <= 1'b1;
          end else begin
            ph_cnt <= ph_cnt + 16'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_field_adjust.sv
// Scoreboard bench: an hour field (wrap, P=2, repeat 16) and a minute field
// (saturate, P=3, no repeat) share the key inputs but have separate starts.
module tb_rtc_field_adjust;

  logic       clk = 1'b0;
  logic       reset, enable, UP, DOWN, start_h, start_m;
  logic [7:0] cur_bcd;

  logic       a_d_h, w_r_h, fa_h, fd_h, busy_h, done_h;
  logic [7:0] bus_h, nb_h;
  logic       a_d_m, w_r_m, fa_m, fd_m, busy_m, done_m;
  logic [7:0] bus_m, nb_m;

  int errors = 0;
  int checks = 0;
  int acnt_h = 0, dcnt_h = 0, ndone_h = 0;
  int acnt_m = 0, dcnt_m = 0, ndone_m = 0;
  logic [7:0] q_h[$];
  logic [7:0] q_m[$];

  always #5 clk = ~clk;

  rtc_field_adjust #(
    .FIELD_ADDR(8'h23), .MIN_BCD(8'h00), .MAX_BCD(8'h23), .WRAP(1'b1),
    .PHASE_CYCLES(2), .REPEAT_CYCLES(16)
  ) dut_h (
    .clk(clk), .reset(reset), .enable(enable), .start(start_h), .UP(UP), .DOWN(DOWN),
    .cur_bcd(cur_bcd), .A_D(a_d_h), .W_R(w_r_h), .bus_out(bus_h), .flag_addr(fa_h),
    .flag_data(fd_h), .busy(busy_h), .done(done_h), .new_bcd(nb_h)
  );

  rtc_field_adjust #(
    .FIELD_ADDR(8'h22), .MIN_BCD(8'h00), .MAX_BCD(8'h59), .WRAP(1'b0),
    .PHASE_CYCLES(3), .REPEAT_CYCLES(0)
  ) dut_m (
    .clk(clk), .reset(reset), .enable(enable), .start(start_m), .UP(UP), .DOWN(DOWN),
    .cur_bcd(cur_bcd), .A_D(a_d_m), .W_R(w_r_m), .bus_out(bus_m), .flag_addr(fa_m),
    .flag_data(fd_m), .busy(busy_m), .done(done_m), .new_bcd(nb_m)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Hour-field monitor: bus contents per phase, phase lengths, written value.
  always @(negedge clk) begin
    if (reset || !enable) begin
      acnt_h = 0;
      dcnt_h = 0;
    end else begin
      if (fa_h) begin
        check("h_addr_bus", {22'd0, a_d_h, w_r_h, bus_h}, {22'd0, 2'b00, 8'h23});
        acnt_h++;
      end
      if (fd_h) begin
        check("h_data_pending", 32'(q_h.size() > 0), 32'd1);
        if (q_h.size() > 0)
          check("h_data_bus", {22'd0, a_d_h, w_r_h, bus_h}, {22'd0, 2'b11, q_h[0]});
        dcnt_h++;
      end
      if (done_h) begin
        check("h_done_pending", 32'(q_h.size() > 0), 32'd1);
        if (q_h.size() > 0) check("h_new_bcd", 32'(nb_h), 32'(q_h.pop_front()));
        check("h_addr_len", acnt_h, 2);
        check("h_data_len", dcnt_h, 2);
        acnt_h = 0;
        dcnt_h = 0;
        ndone_h++;
      end
    end
  end

  // Minute-field monitor.
  always @(negedge clk) begin
    if (reset || !enable) begin
      acnt_m = 0;
      dcnt_m = 0;
    end else begin
      if (fa_m) begin
        check("m_addr_bus", {22'd0, a_d_m, w_r_m, bus_m}, {22'd0, 2'b00, 8'h22});
        acnt_m++;
      end
      if (fd_m) begin
        check("m_data_pending", 32'(q_m.size() > 0), 32'd1);
        if (q_m.size() > 0)
          check("m_data_bus", {22'd0, a_d_m, w_r_m, bus_m}, {22'd0, 2'b11, q_m[0]});
        dcnt_m++;
      end
      if (done_m) begin
        check("m_done_pending", 32'(q_m.size() > 0), 32'd1);
        if (q_m.size() > 0) check("m_new_bcd", 32'(nb_m), 32'(q_m.pop_front()));
        check("m_addr_len", acnt_m, 3);
        check("m_data_len", dcnt_m, 3);
        acnt_m = 0;
        dcnt_m = 0;
        ndone_m++;
      end
    end
  end

  task automatic wait_idle(input bit m);
    logic b;
    b = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      b = m ? busy_m : busy_h;
      if (!b) break;
    end
    check(m ? "m_wait_idle" : "h_wait_idle", 32'(b), 32'd0);
  endtask

  task automatic do_write(input bit m, input logic [7:0] c, input logic u, input logic d,
                          input logic [7:0] e);
    @(negedge clk);
    cur_bcd = c;
    UP      = u;
    DOWN    = d;
    if (m) begin q_m.push_back(e); start_m = 1'b1; end
    else   begin q_h.push_back(e); start_h = 1'b1; end
    @(negedge clk);
    start_h = 1'b0;
    start_m = 1'b0;
    @(negedge clk);
    UP   = 1'b0;
    DOWN = 1'b0;
    wait_idle(m);
  endtask

  task automatic abort_test(input bit use_en);
    logic ok;
    @(negedge clk);
    cur_bcd = 8'h11;
    UP      = 1'b1;
    q_h.push_back(8'h12);
    start_h = 1'b1;
    @(negedge clk);
    start_h = 1'b0;
    @(negedge clk);
    UP = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fd_h) begin ok = 1'b1; break; end
    end
    check("abort_reach_data", 32'(ok), 32'd1);
    if (use_en) enable = 1'b0;
    else        reset  = 1'b1;
    @(negedge clk);
    check(use_en ? "en_clear" : "rst_clear",
          {14'd0, a_d_h, w_r_h, fa_h, fd_h, busy_h, done_h, bus_h, nb_h}, 32'd0);
    enable = 1'b1;
    reset  = 1'b0;
    q_h.delete();
    do_write(1'b0, 8'h11, 1'b1, 1'b0, 8'h12);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    reset = 1'b1; enable = 1'b1; start_h = 1'b0; start_m = 1'b0;
    UP = 1'b0; DOWN = 1'b0; cur_bcd = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_h", {14'd0, a_d_h, w_r_h, fa_h, fd_h, busy_h, done_h, bus_h, nb_h}, 32'd0);
    check("rst_m", {14'd0, a_d_m, w_r_m, fa_m, fd_m, busy_m, done_m, bus_m, nb_m}, 32'd0);
    reset = 1'b0;

    // Cycle-exact latency of an hour write 09 -> 10.
    @(negedge clk);
    cur_bcd = 8'h09; UP = 1'b1; q_h.push_back(8'h10); start_h = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check("lat_busy", 32'(busy_h), 32'(k <= 6));
      check("lat_addr", 32'(fa_h), 32'(k == 2 || k == 3));
      check("lat_data", 32'(fd_h), 32'(k == 4 || k == 5));
      check("lat_done", 32'(done_h), 32'(k == 6));
      if (k == 1) start_h = 1'b0;
      if (k == 2) UP = 1'b0;
    end
    check("h_hold", 32'(nb_h), 32'h10);

    // Hour field: wrap, BCD carry/borrow, invalid input, both/neither keys.
    do_write(1'b0, 8'h23, 1'b1, 1'b0, 8'h00);
    do_write(1'b0, 8'h00, 1'b0, 1'b1, 8'h23);
    do_write(1'b0, 8'h20, 1'b0, 1'b1, 8'h19);
    do_write(1'b0, 8'h1A, 1'b1, 1'b0, 8'h00);
    do_write(1'b0, 8'h15, 1'b1, 1'b1, 8'h15);
    do_write(1'b0, 8'h30, 1'b1, 1'b0, 8'h00);
    do_write(1'b0, 8'h19, 1'b1, 1'b0, 8'h20);
    do_write(1'b0, 8'h05, 1'b0, 1'b0, 8'h05);

    // Minute field: saturate at both ends, carry, invalid nibble, borrow.
    do_write(1'b1, 8'h59, 1'b1, 1'b0, 8'h59);
    do_write(1'b1, 8'h00, 1'b0, 1'b1, 8'h00);
    do_write(1'b1, 8'h39, 1'b1, 1'b0, 8'h40);
    do_write(1'b1, 8'h4F, 1'b0, 1'b1, 8'h00);
    do_write(1'b1, 8'h10, 1'b0, 1'b1, 8'h09);
    do_write(1'b1, 8'h58, 1'b1, 1'b0, 8'h59);

    // Second start during the address phase must be ignored.
    n0 = ndone_h;
    @(negedge clk);
    cur_bcd = 8'h12; UP = 1'b1; q_h.push_back(8'h13); start_h = 1'b1;
    @(negedge clk);
    start_h = 1'b0;
    @(negedge clk);
    UP = 1'b0; DOWN = 1'b1; start_h = 1'b1;
    @(negedge clk);
    start_h = 1'b0; DOWN = 1'b0;
    wait_idle(1'b0);
    repeat (10) @(negedge clk);
    check("busy_one_done", ndone_h - n0, 1);
    check("busy_q_empty", q_h.size(), 0);

    abort_test(1'b0);
    abort_test(1'b1);

    // Auto-repeat with the written value fed back as the current value.
    n0 = ndone_h;
    @(negedge clk);
    cur_bcd = 8'h05; UP = 1'b1;
    q_h.push_back(8'h06);
    q_h.push_back(8'h07);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_h) cur_bcd = nb_h;
    end
    UP = 1'b0;
    wait_idle(1'b0);
    check("rpt_writes", ndone_h - n0, 2);
    check("rpt_cur", 32'(cur_bcd), 32'h07);

    // A repeat fire landing during a started write is dropped.
    n0 = ndone_h;
    @(negedge clk);
    cur_bcd = 8'h07; UP = 1'b1; q_h.push_back(8'h08);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start_h = (i == 12);
    end
    UP = 1'b0;
    wait_idle(1'b0);
    repeat (5) @(negedge clk);
    check("drop_writes", ndone_h - n0, 1);
    check("drop_q_empty", q_h.size(), 0);
    check("m_q_empty", q_m.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
